// File: rtl/instr_mem_sync.sv
// Byte-organised instruction memory: loaded word-by-word in LOAD, then serves
// registered little-endian fetches in RUN with stall/flush and fault flagging.
module instr_mem_sync #(
    parameter int BYTE    = 8,
    parameter int WIDTH_I = 32,
    parameter int DEPTH_I = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ld_en,
    input  logic [WIDTH_I-1:0] ld_addr,
    input  logic [WIDTH_I-1:0] ld_data,
    input  logic               ld_done,
    input  logic               cs_rom,
    input  logic [WIDTH_I-1:0] pc_addr,
    input  logic               stall,
    input  logic               flush,
    output logic [WIDTH_I-1:0] i_out,
    output logic               i_valid,
    output logic               i_fault,
    output logic               ready
);

    localparam int NBYTES = WIDTH_I / BYTE;
    localparam int OW     = $clog2(NBYTES);
    localparam int AW     = $clog2(DEPTH_I);
    localparam logic [WIDTH_I-1:0] LAST_ADDR = WIDTH_I'(DEPTH_I - NBYTES);

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state;
    logic [BYTE-1:0]    mem [DEPTH_I];
    logic [WIDTH_I-1:0] rdata;
    logic               ld_ok;
    logic               pc_ok;

    // Range checks use the full address so nothing aliases or wraps.
    assign ld_ok = (ld_addr[OW-1:0] == '0) && (ld_addr <= LAST_ADDR);
    assign pc_ok = (pc_addr[OW-1:0] == '0) && (pc_addr <= LAST_ADDR);
    assign ready = (state == RUN);

    // Contents intentionally survive rst.
    always_ff @(posedge clk) begin
        if (state == LOAD && ld_en && ld_ok) begin
            for (int b = 0; b < NBYTES; b++) begin
                mem[ld_addr[AW-1:0] + AW'(b)] <= ld_data[b*BYTE +: BYTE];
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int b = 0; b < NBYTES; b++) begin
            rdata[b*BYTE +: BYTE] = mem[pc_addr[AW-1:0] + AW'(b)];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= LOAD;
            i_out   <= '0;
            i_valid <= 1'b0;
            i_fault <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    i_out   <= '0;
                    i_valid <= 1'b0;
                    i_fault <= 1'b0;
                    if (ld_done) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (flush) begin
                        i_out   <= '0;
                        i_valid <= 1'b0;
                        i_fault <= 1'b0;
                    end else if (!stall) begin
                        if (cs_rom) begin
                            i_out   <= pc_ok ? rdata : '0;
                            i_valid <= 1'b1;
                            i_fault <= !pc_ok;
                        end else begin
                            i_out   <= '0;
                            i_valid <= 1'b0;
                            i_fault <= 1'b0;
                        end
                    end
                end
                default: begin
                    state   <= LOAD;
                    i_out   <= '0;
                    i_valid <= 1'b0;
                    i_fault <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_sync.sv
// Directed bench for instr_mem_sync: load, fetch, faults, stall, flush and
// asynchronous reset with retained memory contents.
module tb_instr_mem_sync;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_en;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        ld_done;
    logic        cs_rom;
    logic [31:0] pc_addr;
    logic        stall;
    logic        flush;
    logic [31:0] i_out;
    logic        i_valid;
    logic        i_fault;
    logic        ready;

    int vectors    = 0;
    int miscompares = 0;

    instr_mem_sync #(.BYTE(8), .WIDTH_I(32), .DEPTH_I(256)) dut (
        .clk     (clk),
        .rst     (rst),
        .ld_en   (ld_en),
        .ld_addr (ld_addr),
        .ld_data (ld_data),
        .ld_done (ld_done),
        .cs_rom  (cs_rom),
        .pc_addr (pc_addr),
        .stall   (stall),
        .flush   (flush),
        .i_out   (i_out),
        .i_valid (i_valid),
        .i_fault (i_fault),
        .ready   (ready)
    );

    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 ns before driving/sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        vectors++;
        if ({i_out, i_valid, i_fault, ready} !== 35'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got out=%h v=%b f=%b rdy=%b, want all zero",
                     i_out, i_valid, i_fault, ready);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release_no_edge: ready=%b want 0", ready);
        end
    endtask

    task automatic test_load_phase();
        logic [31:0] addrs [6] = '{32'h0, 32'h4, 32'h8, 32'h2, 32'h100, 32'hFC};
        logic [31:0] datas [6] = '{32'h20010008, 32'h3402000C, 32'h11223344,
                                   32'hFFFFFFFF, 32'hDEADBEEF, 32'hCAFEF00D};
        cs_rom  = 1'b1;
        pc_addr = 32'h0;
        for (int i = 0; i < 6; i++) begin
            ld_en   = 1'b1;
            ld_addr = addrs[i];
            ld_data = datas[i];
            ld_done = (i == 5);
            step();
            vectors++;
            if (i_valid !== 1'b0 || i_out !== 32'h0 || i_fault !== 1'b0) begin
                miscompares++;
                $display("FAIL load_fetch_ignored[%0d]: got out=%h v=%b f=%b want 0/0/0",
                         i, i_out, i_valid, i_fault);
            end
            vectors++;
            if (ready !== (i == 5)) begin
                miscompares++;
                $display("FAIL load_ready[%0d]: ready=%b want %b", i, ready, (i == 5));
            end
        end
        ld_en   = 1'b0;
        ld_done = 1'b0;
        cs_rom  = 1'b0;
    endtask

    task automatic test_fetch();
        logic [31:0] pcs  [6] = '{32'h0, 32'h4, 32'h8, 32'hFC, 32'h6, 32'h100};
        logic [31:0] outs [6] = '{32'h20010008, 32'h3402000C, 32'h11223344,
                                  32'hCAFEF00D, 32'h0, 32'h0};
        logic        flt  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) begin
            cs_rom  = 1'b1;
            pc_addr = pcs[i];
            step();
            vectors++;
            if (i_out !== outs[i] || i_valid !== 1'b1 || i_fault !== flt[i]) begin
                miscompares++;
                $display("FAIL fetch pc=%h: got out=%h v=%b f=%b want out=%h v=1 f=%b",
                         pcs[i], i_out, i_valid, i_fault, outs[i], flt[i]);
            end
        end
        pc_addr = 32'hFFFF_FFFC;
        step();
        vectors++;
        if (i_out !== 32'h0 || i_valid !== 1'b1 || i_fault !== 1'b1) begin
            miscompares++;
            $display("FAIL fetch_no_wrap: got out=%h v=%b f=%b want 0/1/1", i_out, i_valid, i_fault);
        end
        cs_rom = 1'b0;
        step();
        vectors++;
        if (i_out !== 32'h0 || i_valid !== 1'b0 || i_fault !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_no_cs: got out=%h v=%b f=%b want 0/0/0", i_out, i_valid, i_fault);
        end
    endtask

    task automatic test_stall();
        cs_rom  = 1'b1;
        pc_addr = 32'h0;
        step();
        stall   = 1'b1;
        pc_addr = 32'h4;
        for (int i = 0; i < 3; i++) begin
            cs_rom = (i != 1);
            step();
            vectors++;
            if (i_out !== 32'h20010008 || i_valid !== 1'b1 || i_fault !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: got out=%h v=%b f=%b want 20010008/1/0",
                         i, i_out, i_valid, i_fault);
            end
        end
        stall  = 1'b0;
        cs_rom = 1'b1;
        step();
        vectors++;
        if (i_out !== 32'h3402000C || i_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_release: got out=%h v=%b want 3402000c/1", i_out, i_valid);
        end
    endtask

    task automatic test_flush();
        stall   = 1'b1;
        flush   = 1'b1;
        cs_rom  = 1'b1;
        pc_addr = 32'h0;
        step();
        vectors++;
        if (i_out !== 32'h0 || i_valid !== 1'b0 || i_fault !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_over_stall: got out=%h v=%b f=%b want 0/0/0", i_out, i_valid, i_fault);
        end
        stall = 1'b0;
        flush = 1'b0;
        pc_addr = 32'h6;
        step();
        flush = 1'b1;
        step();
        vectors++;
        if (i_fault !== 1'b0 || i_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_clears_fault: got v=%b f=%b want 0/0", i_valid, i_fault);
        end
        flush  = 1'b0;
        cs_rom = 1'b0;
    endtask

    task automatic test_run_ignores_load();
        ld_en   = 1'b1;
        ld_addr = 32'h0;
        ld_data = 32'hFFFFFFFF;
        step();
        ld_en   = 1'b0;
        cs_rom  = 1'b1;
        pc_addr = 32'h0;
        step();
        vectors++;
        if (i_out !== 32'h20010008 || i_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL run_load_ignored: got out=%h v=%b want 20010008/1", i_out, i_valid);
        end
    endtask

    task automatic test_async_reset();
        cs_rom  = 1'b1;
        pc_addr = 32'h4;
        step();
        stall   = 1'b1;
        step();
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if ({i_out, i_valid, i_fault, ready} !== 35'h0) begin
            miscompares++;
            $display("FAIL async_reset: got out=%h v=%b f=%b rdy=%b want all zero",
                     i_out, i_valid, i_fault, ready);
        end
        stall = 1'b0;
        pc_addr = 32'h0;
        step();
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if (ready !== 1'b0 || i_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_deassert: got rdy=%b v=%b want 0/0", ready, i_valid);
        end
        step();
        vectors++;
        if (ready !== 1'b0 || i_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL need_ld_done: got rdy=%b v=%b want 0/0", ready, i_valid);
        end
        ld_done = 1'b1;
        step();
        ld_done = 1'b0;
        vectors++;
        if (ready !== 1'b1 || i_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL relaunch: got rdy=%b v=%b want 1/0", ready, i_valid);
        end
        step();
        vectors++;
        if (i_out !== 32'h20010008 || i_valid !== 1'b1 || i_fault !== 1'b0) begin
            miscompares++;
            $display("FAIL retained_contents: got out=%h v=%b f=%b want 20010008/1/0",
                     i_out, i_valid, i_fault);
        end
        cs_rom = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        ld_en   = 1'b0;
        ld_addr = '0;
        ld_data = '0;
        ld_done = 1'b0;
        cs_rom  = 1'b0;
        pc_addr = '0;
        stall   = 1'b0;
        flush   = 1'b0;
        #12;
        test_reset();
        test_load_phase();
        test_fetch();
        test_stall();
        test_flush();
        test_run_ignores_load();
        test_async_reset();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
